regfile_burst_reader: RTL and testbench
=======================================

Name: regfile_burst_reader

Overview:
- Bus-side reader for the register file. On a Start pulse, sweeps a contiguous address range and streams each register word out over a valid/ready interface with backpressure.
- Drives the register file's read-address port and samples its combinational read data.
- Sits between the register file and downstream consumers (debug dump, UART/serialiser, DMA-style copy).

Parameters:
- AddressWidth, 6, register file address width; the file holds 1<<AddressWidth words.
- RegisterWidth, 16, bits per register word.

Ports:
- Clock  input  1  system clock; all state updates on the rising edge.
- nReset  input  1  asynchronous active-low reset.
- Start  input  1  request a burst; sampled only in IDLE.
- StartAddress  input  AddressWidth  first register to read; sampled with Start.
- Count  input  AddressWidth+1  number of words, 0..(1<<AddressWidth); sampled with Start.
- Busy  output  1  high while a burst is in progress.
- Done  output  1  one-cycle pulse when a burst completes.
- RfAddress  output  AddressWidth  read address to the register file.
- RfReadData  input  RegisterWidth  combinational read data from the register file.
- OutData  output  RegisterWidth  stream data.
- OutValid  output  1  stream valid.
- OutReady  input  1  stream ready from the consumer.
- OutLast  output  1  marks the final beat of a burst; qualified by OutValid.

Behaviour:
- Reset, asynchronous, any state:
  - State goes to IDLE.
  - Busy=0, Done=0, OutValid=0, OutLast=0, OutData=0, RfAddress=0.
  - Internal remaining-count = 0.
  - Reset mid-burst abandons the burst with no Done pulse.
- States are IDLE, STREAM and DONE.
- IDLE:
  - Start=1 and Count>0 at edge N: at N+1, state=STREAM, RfAddress=StartAddress, remaining=Count, Busy=1.
  - Start=1 and Count=0 at edge N: go to DONE, Done=1 at N+1, no beats emitted, Busy stays 0.
- STREAM:
  - The output register can load when OutValid=0 or OutReady=1.
  - On each edge where it can load and remaining>0:
    - OutData <= RfReadData, OutValid <= 1, OutLast <= (remaining==1).
    - RfAddress <= RfAddress+1, wrapping modulo 1<<AddressWidth (e.g. 63 -> 0 at the default width).
    - remaining <= remaining-1.
  - On an edge where OutValid && OutReady and remaining==0: OutValid <= 0 and OutLast <= 0.
  - If that accepted beat had OutLast=1, state <= DONE and Busy <= 0.
  - While OutValid=1 and OutReady=0: OutData, OutLast and RfAddress hold, and remaining does not change.
- DONE: Done=1 for exactly one cycle, then state returns to IDLE.
- Latency and throughput:
  - First beat has OutValid=1 at N+2 after Start at edge N.
  - With OutReady held high, one beat per cycle.
  - Done asserts the cycle after the OutLast handshake.
- Data coherency:
  - Each beat carries the register contents present at its capture edge.
  - A write to the same address on that same edge is not seen (read-before-write).
- Start while Busy=1 or in DONE is ignored.
- OutData is don't-care when OutValid=0, but holds its last value; it is not cleared after the burst.
- Count=(1<<AddressWidth) reads every register exactly once, beginning at StartAddress.

Test Plan:
- Preload registers 0..3 with 0x1111, 0x2222, 0x3333, 0x4444. Start with StartAddress=0, Count=4, OutReady=1.
  -> Beats 0x1111, 0x2222, 0x3333, 0x4444 on consecutive cycles.
  -> First beat 2 cycles after Start; OutLast only on 0x4444.
  -> Done pulses 1 cycle later; Busy drops the same cycle.
- StartAddress=62, Count=4 at default width.
  -> RfAddress sequence 62, 63, 0, 1; data matches those registers in order.
- Backpressure: Count=3, OutReady toggled 1,0,0,1,0,1.
  -> Each beat held stable while OutReady=0.
  -> Exactly 3 handshakes, no duplicates or drops, OutLast on the third.
- Start with Count=0.
  -> No OutValid; Done=1 one cycle later; Busy never asserts.
- Count=64 from StartAddress=5 after preloading reg[i]=i.
  -> 64 beats 5..63, 0..4.
  -> A second Start issued mid-burst is ignored.
- Drop nReset during beat 2 of a Count=8 burst.
  -> All outputs go to 0 immediately and no Done pulse.
  -> After release, a new burst from address 0 runs correctly.

Source files
------------

// File: rtl/regfile_burst_reader_if.sv
// Bundles the start/status, register-file read and stream signals of the burst reader.
// The master modport is the reader; the slave modport is the surrounding system.
interface regfile_burst_reader_if #(
    parameter int unsigned AddressWidth  = 6,
    parameter int unsigned RegisterWidth = 16
);
    logic                     Start;
    logic [AddressWidth-1:0]  StartAddress;
    logic [AddressWidth:0]    Count;
    logic                     Busy;
    logic                     Done;
    logic [AddressWidth-1:0]  RfAddress;
    logic [RegisterWidth-1:0] RfReadData;
    logic [RegisterWidth-1:0] OutData;
    logic                     OutValid;
    logic                     OutReady;
    logic                     OutLast;

    modport master (
        input  Start, StartAddress, Count, RfReadData, OutReady,
        output Busy, Done, RfAddress, OutData, OutValid, OutLast
    );

    modport slave (
        output Start, StartAddress, Count, RfReadData, OutReady,
        input  Busy, Done, RfAddress, OutData, OutValid, OutLast
    );
endinterface

// File: rtl/regfile_burst_reader.sv
// Sweeps a contiguous register-file range on Start and streams each word out
// over a valid/ready port with backpressure; Done pulses once per burst.
module regfile_burst_reader #(
    parameter int unsigned AddressWidth  = 6,
    parameter int unsigned RegisterWidth = 16
) (
    input  logic                  Clock,
    input  logic                  nReset,
    regfile_burst_reader_if.master bus
);
    localparam int unsigned CountWidth = AddressWidth + 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_STREAM,
        ST_DONE
    } state_e;

    state_e                   state_q, state_d;
    logic [CountWidth-1:0]    remaining_q, remaining_d;
    logic [AddressWidth-1:0]  rf_addr_q, rf_addr_d;
    logic [RegisterWidth-1:0] out_data_q, out_data_d;
    logic                     out_valid_q, out_valid_d;
    logic                     out_last_q, out_last_d;
    logic                     busy_q, busy_d;
    logic                     done_q, done_d;

    logic load_c;
    logic rem_zero_c;

    // Output register is free when empty or being drained this edge.
    assign load_c     = !out_valid_q || bus.OutReady;
    assign rem_zero_c = (remaining_q == '0);

    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            state_q     <= ST_IDLE;
            remaining_q <= '0;
            rf_addr_q   <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
            rf_addr_q   <= rf_addr_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        rf_addr_d   = rf_addr_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;
        busy_d      = busy_q;
        done_d      = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (bus.Start) begin
                    if (bus.Count != '0) begin
                        state_d     = ST_STREAM;
                        rf_addr_d   = bus.StartAddress;
                        remaining_d = bus.Count;
                        busy_d      = 1'b1;
                    end else begin
                        // Empty burst completes immediately without emitting beats.
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                    end
                end
            end

            ST_STREAM: begin
                if (load_c && !rem_zero_c) begin
                    out_data_d  = bus.RfReadData;
                    out_valid_d = 1'b1;
                    out_last_d  = (remaining_q == CountWidth'(1));
                    rf_addr_d   = rf_addr_q + AddressWidth'(1);
                    remaining_d = remaining_q - CountWidth'(1);
                end else if (out_valid_q && bus.OutReady) begin
                    out_valid_d = 1'b0;
                    out_last_d  = 1'b0;
                    if (out_last_q) begin
                        state_d = ST_DONE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end
                end
            end

            ST_DONE: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign bus.Busy      = busy_q;
    assign bus.Done      = done_q;
    assign bus.RfAddress = rf_addr_q;
    assign bus.OutData   = out_data_q;
    assign bus.OutValid  = out_valid_q;
    assign bus.OutLast   = out_last_q;

endmodule

// File: tb/tb_regfile_burst_reader.sv
// Directed bench for regfile_burst_reader: a behavioural register file feeds the
// reader and every streamed beat is checked against the bench's own copy.
module tb_regfile_burst_reader;
    localparam int unsigned AW = 6;
    localparam int unsigned RW = 16;
    localparam int unsigned DEPTH = 1 << AW;

    logic Clock;
    logic nReset;
    logic [RW-1:0] rf [DEPTH];

    int total_checks;
    int passed_checks;
    int failed_checks;

    regfile_burst_reader_if #(.AddressWidth(AW), .RegisterWidth(RW)) bus ();

    regfile_burst_reader #(.AddressWidth(AW), .RegisterWidth(RW)) dut (
        .Clock (Clock),
        .nReset(nReset),
        .bus   (bus)
    );

    assign bus.RfReadData = rf[bus.RfAddress];

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_checks++;
        assert (obs === exp) passed_checks++;
        else begin
            failed_checks++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    // Launch a burst and collect handshakes until Done. Bit k of pat is OutReady
    // in the k-th cycle after Start; poke issues a stray Start mid-burst.
    task automatic burst(input string tag, input int sa, input int cnt,
                         input logic [15:0] pat, input bit poke);
        logic [RW-1:0] beats[$];
        bit            lasts[$];
        logic [15:0]   p;
        logic [RW-1:0] prev_data;
        logic          prev_last;
        bit            prev_stall;
        bit            done_seen;
        int            k;
        p          = pat;
        prev_data  = '0;
        prev_last  = 1'b0;
        prev_stall = 1'b0;
        done_seen  = 1'b0;
        k          = 0;
        bus.Start        = 1'b1;
        bus.StartAddress = AW'(sa);
        bus.Count        = (AW+1)'(cnt);
        tick();
        bus.Start = 1'b0;
        while (!done_seen && k < 400) begin
            bus.OutReady = p[0];
            p = {1'b1, p[15:1]};
            if (poke && k == 10) begin
                bus.Start        = 1'b1;
                bus.StartAddress = '0;
                bus.Count        = (AW+1)'(1);
            end else begin
                bus.Start = 1'b0;
            end
            if (bus.Done) begin
                done_seen = 1'b1;
            end else begin
                if (prev_stall) begin
                    check({tag, " stall data"}, 32'(bus.OutData), 32'(prev_data));
                    check({tag, " stall last"}, 32'(bus.OutLast), 32'(prev_last));
                end
                if (bus.OutValid && bus.OutReady) begin
                    beats.push_back(bus.OutData);
                    lasts.push_back(bus.OutLast);
                end
                prev_stall = bus.OutValid && !bus.OutReady;
                prev_data  = bus.OutData;
                prev_last  = bus.OutLast;
                tick();
                k++;
            end
        end
        bus.Start    = 1'b0;
        bus.OutReady = 1'b1;
        check({tag, " done seen"}, 32'(done_seen), 32'd1);
        check({tag, " beat count"}, 32'(beats.size()), 32'(cnt));
        check({tag, " busy after"}, 32'(bus.Busy), 32'd0);
        for (int i = 0; i < beats.size(); i++) begin
            check($sformatf("%s beat%0d data", tag, i), 32'(beats[i]),
                  32'(rf[(sa + i) % DEPTH]));
            check($sformatf("%s beat%0d last", tag, i), 32'(lasts[i]),
                  32'(i == cnt - 1));
        end
        tick();
        check({tag, " done pulse width"}, 32'(bus.Done), 32'd0);
    endtask

    initial begin
        total_checks  = 0;
        passed_checks = 0;
        failed_checks = 0;
        nReset           = 1'b0;
        bus.Start        = 1'b0;
        bus.StartAddress = '0;
        bus.Count        = '0;
        bus.OutReady     = 1'b1;
        for (int i = 0; i < DEPTH; i++) rf[i] = 16'hA000 + 16'(i);
        rf[0] = 16'h1111;
        rf[1] = 16'h2222;
        rf[2] = 16'h3333;
        rf[3] = 16'h4444;

        // Reset state
        #2;
        check("rst busy", 32'(bus.Busy), 32'd0);
        check("rst done", 32'(bus.Done), 32'd0);
        check("rst valid", 32'(bus.OutValid), 32'd0);
        check("rst last", 32'(bus.OutLast), 32'd0);
        check("rst data", 32'(bus.OutData), 32'd0);
        check("rst addr", 32'(bus.RfAddress), 32'd0);
        tick();
        tick();
        nReset = 1'b1;
        tick();

        // Basic 4-beat burst with exact cycle timing
        bus.Start        = 1'b1;
        bus.StartAddress = '0;
        bus.Count        = (AW+1)'(4);
        tick();
        bus.Start = 1'b0;
        check("b1 busy", 32'(bus.Busy), 32'd1);
        check("b1 addr", 32'(bus.RfAddress), 32'd0);
        check("b1 no early valid", 32'(bus.OutValid), 32'd0);
        tick();
        check("b1 beat0 valid", 32'(bus.OutValid), 32'd1);
        check("b1 beat0 data", 32'(bus.OutData), 32'h1111);
        check("b1 beat0 last", 32'(bus.OutLast), 32'd0);
        tick();
        check("b1 beat1 data", 32'(bus.OutData), 32'h2222);
        tick();
        check("b1 beat2 data", 32'(bus.OutData), 32'h3333);
        check("b1 beat2 last", 32'(bus.OutLast), 32'd0);
        tick();
        check("b1 beat3 data", 32'(bus.OutData), 32'h4444);
        check("b1 beat3 last", 32'(bus.OutLast), 32'd1);
        check("b1 beat3 busy", 32'(bus.Busy), 32'd1);
        tick();
        check("b1 done", 32'(bus.Done), 32'd1);
        check("b1 busy drop", 32'(bus.Busy), 32'd0);
        check("b1 valid drop", 32'(bus.OutValid), 32'd0);
        check("b1 data held", 32'(bus.OutData), 32'h4444);
        tick();
        check("b1 done one cycle", 32'(bus.Done), 32'd0);

        // Address wrap 62,63,0,1
        bus.Start        = 1'b1;
        bus.StartAddress = AW'(62);
        bus.Count        = (AW+1)'(4);
        tick();
        bus.Start = 1'b0;
        check("wrap addr0", 32'(bus.RfAddress), 32'd62);
        tick();
        check("wrap addr1", 32'(bus.RfAddress), 32'd63);
        check("wrap data0", 32'(bus.OutData), 32'hA03E);
        tick();
        check("wrap addr2", 32'(bus.RfAddress), 32'd0);
        check("wrap data1", 32'(bus.OutData), 32'hA03F);
        tick();
        check("wrap addr3", 32'(bus.RfAddress), 32'd1);
        check("wrap data2", 32'(bus.OutData), 32'h1111);
        tick();
        check("wrap data3", 32'(bus.OutData), 32'h2222);
        check("wrap last", 32'(bus.OutLast), 32'd1);
        tick();
        check("wrap done", 32'(bus.Done), 32'd1);
        tick();

        // Backpressure: ready 1,0,0,1,0,1 then high
        burst("bp", 10, 3, 16'hFFE9, 1'b0);

        // Zero-length burst
        bus.Start = 1'b1;
        bus.Count = '0;
        tick();
        bus.Start = 1'b0;
        check("c0 done", 32'(bus.Done), 32'd1);
        check("c0 busy", 32'(bus.Busy), 32'd0);
        check("c0 valid", 32'(bus.OutValid), 32'd0);
        tick();
        check("c0 done clear", 32'(bus.Done), 32'd0);
        check("c0 busy after", 32'(bus.Busy), 32'd0);
        check("c0 valid after", 32'(bus.OutValid), 32'd0);

        // Full sweep of every register with a stray Start mid-burst
        for (int i = 0; i < DEPTH; i++) rf[i] = 16'(i);
        burst("full", 5, 64, 16'hFFFF, 1'b1);

        // Reset during beat 2 of an 8-beat burst
        bus.Start        = 1'b1;
        bus.StartAddress = '0;
        bus.Count        = (AW+1)'(8);
        tick();
        bus.Start = 1'b0;
        tick();
        tick();
        tick();
        check("mid beat2 data", 32'(bus.OutData), 32'd2);
        #2;
        nReset = 1'b0;
        #1;
        check("mid rst busy", 32'(bus.Busy), 32'd0);
        check("mid rst valid", 32'(bus.OutValid), 32'd0);
        check("mid rst data", 32'(bus.OutData), 32'd0);
        check("mid rst addr", 32'(bus.RfAddress), 32'd0);
        check("mid rst last", 32'(bus.OutLast), 32'd0);
        tick();
        nReset = 1'b1;
        tick();
        check("mid no done", 32'(bus.Done), 32'd0);
        check("mid idle valid", 32'(bus.OutValid), 32'd0);
        burst("post rst", 0, 4, 16'hFFFF, 1'b0);

        $display("%0d/%0d checks passed", passed_checks, total_checks);
        $finish;
    end

endmodule
